// File: rtl/alu_wb.sv
// ALU writeback stage: pairs each ALU result with its destination register and
// queues it in a 4-entry FIFO. Define ALU_WB_FWD_EN to add the operand-bypass outputs.
module alu_wb #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [3:0]        issue_alufn,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] alu_res,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
  input  logic              wb_ready
`ifdef ALU_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam logic [3:0] ALUFN_DIV = 4'b0100;

  // Unsupported opcodes: DIV, plus the undefined codes 0, 14 and 15.
  function automatic logic unsupported(input logic [3:0] fn);
    return (fn == ALUFN_DIV) || (fn == 4'd0) || (fn > 4'd13);
  endfunction

  logic              vld_p1;
  logic [4:0]        rd_p1;
  logic              err_p1;

  logic [4:0]        mem_rd   [4];
  logic [DATA_W-1:0] mem_data [4];
  logic              mem_err  [4];
  logic [1:0]        wptr;
  logic [1:0]        rptr;
  logic [2:0]        count;

  logic              accept;
  logic              push;
  logic              pop;

  // Pending and buffered entries together may never exceed the FIFO depth.
  assign issue_ready = ({1'b0, count} + {3'b000, vld_p1}) < 4'd4;
  assign accept      = issue_valid & clk_en & issue_ready;
  assign push        = vld_p1 & (rd_p1 != 5'd0);
  assign pop         = (count != 3'd0) & wb_ready;

  // Stage p1: pending entry, waits one edge for the ALU result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_p1  <= issue_rd;
      err_p1 <= unsupported(issue_alufn);
    end
  end

  // Stage p2: FIFO toward the register-file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr]   <= rd_p1;
      mem_data[wptr] <= err_p1 ? '0 : alu_res;
      mem_err[wptr]  <= err_p1;
    end
  end

  // Head fields are forced to zero when empty so reset and idle are clean.
  assign wb_valid = (count != 3'd0);
  assign wb_rd    = wb_valid ? mem_rd[rptr]   : 5'd0;
  assign wb_data  = wb_valid ? mem_data[rptr] : '0;
  assign wb_err   = wb_valid ? mem_err[rptr]  : 1'b0;

`ifdef ALU_WB_FWD_EN
  assign fwd_valid = vld_p1 & (rd_p1 != 5'd0);
  assign fwd_rd    = rd_p1;
  assign fwd_data  = alu_res;
`endif

endmodule

// File: tb/tb_alu_wb.sv
// Self-checking bench for alu_wb: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_alufn;
  logic        issue_ready;
  logic [31:0] alu_res;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic        wb_ready;
`ifdef ALU_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_wb dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_alufn(issue_alufn),
    .issue_ready(issue_ready), .alu_res(alu_res),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
    .wb_ready(wb_ready)
`ifdef ALU_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of writeback entries plus one pending slot.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } ent_t;

  ent_t       q[$];
  logic       m_pv;
  logic [4:0] m_prd;
  logic       m_perr;

  function automatic logic bad_op(input logic [3:0] fn);
    return !(fn >= 4'd1 && fn <= 4'd13) || fn == 4'd4;
  endfunction

  function automatic logic m_ready();
    return (q.size() + int'(m_pv)) < 4;
  endfunction

  function automatic logic [38:0] m_head();
    if (q.size() == 0) return 39'd0;
    return {1'b1, q[0].rd, q[0].data, q[0].err};
  endfunction

  function automatic logic [38:0] dut_head();
    return {wb_valid, wb_rd, wb_data, wb_err};
  endfunction

  // Drives one cycle of inputs, advances the model over the edge, returns whether the issue was taken.
  task automatic cycle(input logic iv, input logic [4:0] rd, input logic [3:0] fn,
                       input logic [31:0] res, input logic wr, input logic en, output logic acc);
    ent_t e;
    issue_valid = iv; issue_rd = rd; issue_alufn = fn;
    alu_res = res; wb_ready = wr; clk_en = en;
    acc = iv && en && m_ready();
    @(posedge clk);
    if (q.size() != 0 && wr) void'(q.pop_front());
    if (m_pv && m_prd != 5'd0) begin
      e.rd = m_prd; e.err = m_perr; e.data = m_perr ? 32'd0 : res;
      q.push_back(e);
    end
    m_pv = acc;
    if (acc) begin m_prd = rd; m_perr = bad_op(fn); end
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    m_pv = 1'b0; m_prd = 5'd0; m_perr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
    issue_alufn = 4'd0; alu_res = 32'd0; wb_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_head() !== 39'd0 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state head=%h ready=%b required head=0 ready=1", dut_head(), issue_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic acc;
    cycle(1'b1, 5'd5, 4'd1, $urandom, 1'b1, 1'b1, acc);
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency1 wb_valid=%b required 0", wb_valid);
    end
    cycle(1'b0, 5'd0, 4'd0, 32'h0000000C, 1'b1, 1'b1, acc);
    vectors++;
    if (dut_head() !== {1'b1, 5'd5, 32'h0000000C, 1'b0}) begin
      miscompares++;
      $display("FAIL single_head got=%h required=%h", dut_head(), {1'b1, 5'd5, 32'h0000000C, 1'b0});
    end
    cycle(1'b0, 5'd0, 4'd0, $urandom, 1'b1, 1'b1, acc);
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pop wb_valid=%b required 0", wb_valid);
    end
  endtask

  task automatic test_fill();
    logic acc;
    int cur = 1;
    int taken = 0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (issue_ready !== m_ready()) begin
        miscompares++;
        $display("FAIL fill_ready cyc=%0d got=%b required=%b", i, issue_ready, m_ready());
      end
      cycle(cur <= 6, 5'(cur), 4'd2, $urandom, 1'b0, 1'b1, acc);
      if (acc) begin cur++; taken++; end
    end
    vectors++;
    if (taken != 4 || issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_accepts taken=%0d ready=%b required 4 and 0", taken, issue_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'(k)) begin
        miscompares++;
        $display("FAIL fill_order valid=%b rd=%0d required 1 and %0d", wb_valid, wb_rd, k);
      end
      cycle(1'b0, 5'd0, 4'd0, $urandom, 1'b1, 1'b1, acc);
    end
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_drained wb_valid=%b required 0", wb_valid);
    end
  endtask

  task automatic test_rd0();
    logic acc;
    cycle(1'b1, 5'd0, 4'd1, $urandom, 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wb_valid !== 1'b0 || issue_ready !== m_ready()) begin
        miscompares++;
        $display("FAIL rd0_discard valid=%b ready=%b required 0 and %b", wb_valid, issue_ready, m_ready());
      end
      cycle(1'b0, 5'd0, 4'd0, $urandom, 1'b0, 1'b1, acc);
    end
  endtask

  task automatic test_div();
    logic acc;
    cycle(1'b1, 5'd7, 4'b0100, $urandom, 1'b0, 1'b1, acc);
    cycle(1'b1, 5'd8, 4'd15, 32'hDEADBEEF, 1'b0, 1'b1, acc);
    cycle(1'b1, 5'd9, 4'd13, 32'h12345678, 1'b0, 1'b1, acc);
    cycle(1'b0, 5'd0, 4'd0, 32'hCAFEF00D, 1'b0, 1'b1, acc);
    vectors++;
    if (dut_head() !== {1'b1, 5'd7, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL div_err got=%h required=%h", dut_head(), {1'b1, 5'd7, 32'd0, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (dut_head() !== m_head()) begin
        miscompares++;
        $display("FAIL div_drain got=%h required=%h", dut_head(), m_head());
      end
      cycle(1'b0, 5'd0, 4'd0, $urandom, 1'b1, 1'b1, acc);
    end
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL div_empty wb_valid=%b required 0", wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [4:0] rd = 5'd10;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, rd, 4'd3, $urandom, i >= 5, 1'b1, acc);
      if (acc) rd++;
      vectors++;
      if (dut_head() !== m_head() || issue_ready !== m_ready()) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d head=%h ready=%b required head=%h ready=%b",
                 i, dut_head(), issue_ready, m_head(), m_ready());
      end
    end
    while (q.size() != 0 || m_pv) begin
      cycle(1'b0, 5'd0, 4'd0, $urandom, 1'b1, 1'b1, acc);
      vectors++;
      if (dut_head() !== m_head()) begin
        miscompares++;
        $display("FAIL b2b_drain head=%h required=%h", dut_head(), m_head());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(20 + i), 4'd1, $urandom, 1'b0, 1'b1, acc);
    vectors++;
    if (q.size() != 3 || !m_pv || wb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_setup wb_valid=%b required 1", wb_valid);
    end
    #2 rst = 1'b1;
    #1;
    model_clear();
    vectors++;
    if (dut_head() !== 39'd0 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_async head=%h ready=%b required head=0 ready=1", dut_head(), issue_ready);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 5'd0, 4'd0, $urandom, 1'b1, 1'b1, acc);
      vectors++;
      if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rstmid_stale valid=%b ready=%b required 0 and 1", wb_valid, issue_ready);
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    logic have = 1'b0;
    logic [4:0] rd = 5'd0;
    logic [3:0] fn = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        have = 1'b1;
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        fn = 4'($urandom);
      end
      vectors++;
      if (issue_ready !== m_ready()) begin
        miscompares++;
        $display("FAIL rand_ready cyc=%0d got=%b required=%b", i, issue_ready, m_ready());
      end
      cycle(have, rd, fn, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, acc);
      if (acc) have = 1'b0;
      vectors++;
      if (dut_head() !== m_head()) begin
        miscompares++;
        $display("FAIL rand_head cyc=%0d got=%h required=%h", i, dut_head(), m_head());
      end
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 5'd0, 4'd0, $urandom, 1'b1, 1'b1, acc);
    vectors++;
    if (wb_valid !== 1'b0 || q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain wb_valid=%b required 0", wb_valid);
    end
  endtask

`ifdef ALU_WB_FWD_EN
  task automatic test_fwd();
    logic acc;
    logic [31:0] r;
    cycle(1'b1, 5'd9, 4'd1, $urandom, 1'b1, 1'b1, acc);
    r = $urandom;
    alu_res = r;
    #1;
    vectors++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd9 || fwd_data !== r) begin
      miscompares++;
      $display("FAIL fwd got v=%b rd=%0d d=%h required 1 9 %h", fwd_valid, fwd_rd, fwd_data, r);
    end
    cycle(1'b0, 5'd0, 4'd0, r, 1'b1, 1'b1, acc);
    cycle(1'b0, 5'd0, 4'd0, $urandom, 1'b1, 1'b1, acc);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_rd0();
    test_div();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_WB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
